// File: rtl/matrix_mem_agent_if.sv
// Transaction and host-preload bundle between the matrix multiplier (master) and its memory agent (slave).
// The host side is a plain synchronous port and has no handshake.
interface matrix_mem_agent_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          req;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [31:0]   req_wdata;
  logic          ack;
  logic [31:0]   rdata;
  logic          err;
  logic          busy;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [31:0]   host_rdata;
  logic [15:0]   txn_count;

  modport master (
    output req, req_addr, req_we, req_wdata, host_we, host_addr, host_wdata,
    input  ack, rdata, err, busy, host_rdata, txn_count
  );

  modport slave (
    input  req, req_addr, req_we, req_wdata, host_we, host_addr, host_wdata,
    output ack, rdata, err, busy, host_rdata, txn_count
  );
endinterface

// File: rtl/matrix_mem_agent.sv
// Word memory answering multiplier load/store requests with a fixed LAT-cycle ack plus a host preload port.
// Latency: ack LAT cycles after accept, host_rdata one cycle; no backpressure, requests are ignored while busy.
module matrix_mem_agent #(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  matrix_mem_agent_if.slave mb
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          w_accept;
  logic          w_resp;
  logic          w_rej;
  logic          w_mem_we;

  logic [AW-1:0] r_idx;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic          r_rej;

  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic [31:0]   r_host_rdata;
  logic [15:0]   r_txn_count;
  logic [31:0]   r_mem [DEPTH];

  // Out-of-range or misaligned addresses are decided once, at accept.
  assign w_rej    = (mb.req_addr[1:0] != 2'b00) || (mb.req_addr >= 32'(4 * DEPTH));
  assign w_mem_we = w_resp && r_we && !r_rej && !rst;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mb.req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 4'(LAT - 1);
          w_state_nxt = (LAT == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_idx   <= mb.req_addr[AW+1:2];
      r_we    <= mb.req_we;
      r_wdata <= mb.req_wdata;
      r_rej   <= w_rej;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= 32'd0;
      r_txn_count  <= 16'd0;
      r_host_rdata <= 32'd0;
    end else begin
      r_ack        <= w_resp;
      r_host_rdata <= r_mem[mb.host_addr];
      if (w_resp) begin
        r_err       <= r_rej;
        r_txn_count <= r_txn_count + 16'd1;
        if (r_rej) begin
          r_rdata <= 32'hDEADBEEF;
        end else if (r_we) begin
          r_rdata <= 32'd0;
        end else begin
          r_rdata <= r_mem[r_idx];
        end
      end
    end
  end

  // Request write is issued last so it wins a same-word collision with the host.
  always_ff @(posedge clk) begin
    if (mb.host_we) begin
      r_mem[mb.host_addr] <= mb.host_wdata;
    end
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign mb.ack        = r_ack;
  assign mb.err        = r_err;
  assign mb.rdata      = r_rdata;
  assign mb.busy       = (r_state != S_IDLE);
  assign mb.host_rdata = r_host_rdata;
  assign mb.txn_count  = r_txn_count;
endmodule

// File: tb/tb_matrix_mem_agent.sv
// Directed bench for matrix_mem_agent: a timing/memory model at transaction level is checked every cycle,
// and literal expectations pin the model on the key scenarios.
module tb_matrix_mem_agent;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  bit   chk_en;

  matrix_mem_agent_if #(.DEPTH(DEPTH)) mb ();

  matrix_mem_agent #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .mb  (mb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request accepted while idle completes LAT edges later.
  int          cyc;
  bit          m_pend;
  int          m_acc;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  bit          m_we;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          e_ack;
  bit          e_err;
  logic [31:0] e_rdata;
  logic [15:0] e_cnt;
  logic [31:0] e_hrd;
  bit          e_hrd_ok;

  always @(posedge clk) begin
    bit rej;
    cyc++;
    if (rst) begin
      m_pend   = 1'b0;
      e_ack    = 1'b0;
      e_err    = 1'b0;
      e_rdata  = 32'd0;
      e_cnt    = 16'd0;
      e_hrd    = 32'd0;
      e_hrd_ok = 1'b1;
      if (mb.host_we) begin
        m_mem[mb.host_addr]   = mb.host_wdata;
        m_known[mb.host_addr] = 1'b1;
      end
    end else begin
      e_hrd    = m_mem[mb.host_addr];
      e_hrd_ok = m_known[mb.host_addr];
      e_ack    = 1'b0;
      if (m_pend && (cyc - m_acc == LAT)) begin
        rej     = (m_addr % 4 != 0) || (m_addr >= 4 * DEPTH);
        e_ack   = 1'b1;
        e_err   = rej;
        e_cnt   = e_cnt + 16'd1;
        e_rdata = rej ? 32'hDEADBEEF : (m_we ? 32'd0 : m_mem[m_addr / 4]);
        m_pend  = 1'b0;
        if (mb.host_we) begin
          m_mem[mb.host_addr]   = mb.host_wdata;
          m_known[mb.host_addr] = 1'b1;
        end
        if (!rej && m_we) begin
          m_mem[m_addr / 4]   = m_wd;
          m_known[m_addr / 4] = 1'b1;
        end
      end else begin
        if (mb.host_we) begin
          m_mem[mb.host_addr]   = mb.host_wdata;
          m_known[mb.host_addr] = 1'b1;
        end
        if (!m_pend && mb.req) begin
          m_pend = 1'b1;
          m_acc  = cyc;
          m_addr = mb.req_addr;
          m_we   = mb.req_we;
          m_wd   = mb.req_wdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", mb.ack, e_ack);
      chk("busy", mb.busy, m_pend);
      chk("err", mb.err, e_err);
      chk("rdata", mb.rdata, e_rdata);
      chk("txn_count", mb.txn_count, e_cnt);
      if (e_hrd_ok) chk("host_rdata", mb.host_rdata, e_hrd);
    end
  end

  // Called at a negedge; returns at the negedge where ack is visible, so calls chain back-to-back.
  task automatic do_txn(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    mb.req = 1'b1; mb.req_addr = addr; mb.req_we = we; mb.req_wdata = wd;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1) mb.req = 1'b0;
      if (mb.ack) begin
        got = 1'b1;
        lat = i - 1;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", lat, LAT);
    rd = mb.rdata;
    er = mb.err;
  endtask

  // Request whose completion edge coincides with a host write.
  task automatic txn_host(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                          input int haddr, input logic [31:0] hwd, output logic [31:0] rd);
    mb.req = 1'b1; mb.req_addr = addr; mb.req_we = we; mb.req_wdata = wd;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i == 1) mb.req = 1'b0;
      if (i == LAT) begin
        mb.host_we = 1'b1; mb.host_addr = 6'(haddr); mb.host_wdata = hwd;
      end
    end
    @(negedge clk);
    mb.host_we = 1'b0;
    chk("same_edge_ack", mb.ack, 1);
    rd = mb.rdata;
  endtask

  task automatic host_write(input int idx, input logic [31:0] d);
    mb.host_we = 1'b1; mb.host_addr = 6'(idx); mb.host_wdata = d;
    @(negedge clk);
    mb.host_we = 1'b0;
  endtask

  task automatic host_read(input int idx, output logic [31:0] d);
    mb.host_addr = 6'(idx);
    @(negedge clk);
    d = mb.host_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] rd2;
    bit          er;
    n_tests = 0; n_fail = 0; chk_en = 1'b0;
    rst = 1'b1;
    mb.req = 1'b0; mb.req_addr = 32'd0; mb.req_we = 1'b0; mb.req_wdata = 32'd0;
    mb.host_we = 1'b0; mb.host_addr = '0; mb.host_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_ack", mb.ack, 0);
    chk("reset_busy", mb.busy, 0);
    chk("reset_rdata", mb.rdata, 0);
    chk("reset_txn", mb.txn_count, 0);
    chk("reset_host_rdata", mb.host_rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) host_write(i, 32'hA500_0000 + i);

    // Basic read of a host-preloaded word.
    host_write(3, 32'h1234_5678);
    do_txn(32'h0C, 1'b0, 32'd0, rd, er);
    chk("rd_word3", rd, 32'h1234_5678);
    chk("rd_word3_err", 32'(er), 0);
    chk("rd_word3_cnt", mb.txn_count, 1);

    // Write then back-to-back read of the same word.
    do_txn(32'h10, 1'b1, 32'hCAFE_F00D, rd, er);
    chk("wr_rdata_zero", rd, 0);
    do_txn(32'h10, 1'b0, 32'd0, rd, er);
    chk("b2b_readback", rd, 32'hCAFE_F00D);

    // Rejected transactions, including writes that must not land.
    do_txn(32'h0E, 1'b0, 32'd0, rd, er);
    chk("misalign_err", 32'(er), 1);
    chk("misalign_rdata", rd, 32'hDEAD_BEEF);
    do_txn(32'(4 * DEPTH), 1'b0, 32'd0, rd, er);
    chk("range_err", 32'(er), 1);
    chk("range_rdata", rd, 32'hDEAD_BEEF);
    do_txn(32'h0F, 1'b1, 32'hBADB_AD01, rd, er);
    do_txn(32'(4 * DEPTH) + 32'h0C, 1'b1, 32'hBADB_AD02, rd, er);
    chk("reject_wr_err", 32'(er), 1);
    chk("reject_cnt", mb.txn_count, 7);
    host_read(3, rd);
    chk("reject_mem_intact", rd, 32'h1234_5678);

    // Same-edge collisions with the host port.
    txn_host(32'h14, 1'b1, 32'hAAAA_0000, 5, 32'h5555_FFFF, rd);
    host_read(5, rd);
    chk("collide_req_wins", rd, 32'hAAAA_0000);
    txn_host(32'h18, 1'b0, 32'd0, 6, 32'h6666_6666, rd);
    chk("collide_read_old", rd, 32'hA500_0006);
    host_read(6, rd);
    chk("collide_host_new", rd, 32'h6666_6666);

    // Host port read-before-write.
    mb.host_addr = 6'd9; mb.host_we = 1'b1; mb.host_wdata = 32'h9999_0009;
    @(negedge clk);
    chk("host_rbw_old", mb.host_rdata, 32'hA500_0009);
    mb.host_we = 1'b0;
    @(negedge clk);
    chk("host_rbw_new", mb.host_rdata, 32'h9999_0009);

    // Reset during WAIT of a write to word 7, with a req in the reset cycle.
    mb.req = 1'b1; mb.req_addr = 32'h1C; mb.req_we = 1'b1; mb.req_wdata = 32'hDEAD_0007;
    @(negedge clk);
    rst = 1'b1; mb.req_addr = 32'h20; mb.req_we = 1'b0;
    @(negedge clk);
    rst = 1'b0; mb.req = 1'b0;
    chk("rst_busy", mb.busy, 0);
    chk("rst_txn", mb.txn_count, 0);
    chk("rst_ack", mb.ack, 0);
    repeat (4) @(negedge clk);
    host_read(7, rd);
    chk("rst_word7", rd, 32'hA500_0007);

    // Multiplier load/store sequence, each request issued on the previous ack.
    for (int i = 0; i < 18; i++) host_write(i, 32'h4D00_0000 + 32'(i * 3));
    for (int i = 0; i < 18; i++) begin
      do_txn(32'(i * 4), 1'b0, 32'd0, rd, er);
      chk("seq_read", rd, 32'h4D00_0000 + 32'(i * 3));
    end
    for (int i = 0; i < 9; i++) do_txn(32'(i * 4), 1'b1, 32'hB000_0000 + 32'(i), rd, er);
    chk("seq_cnt", mb.txn_count, 27);
    for (int i = 0; i < 10; i++) begin
      host_read(i, rd2);
      chk("seq_mem", rd2, (i < 9) ? 32'hB000_0000 + 32'(i) : 32'h4D00_001B);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_mem_agent.md
MATRIX_MEM_AGENT -- requirements
Module: matrix_mem_agent

Interface
REQ-001 Parameter DEPTH, 64, number of 32-bit words in local storage (power of two, 8..1024).
REQ-002 Parameter LAT, 2, request-accept to ack latency in cycles (1..15).
REQ-003 Port clk  input  1  single clock; every register updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port req  input  1  transaction request (level) from the multiplier's start_memory_transaction.
REQ-006 Port req_addr  input  32  byte address of the transaction.
REQ-007 Port req_we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 Port req_wdata  input  32  write data; sampled with req.
REQ-009 Port ack  output  1  one-cycle completion pulse; drives done_memory_transaction.
REQ-010 Port rdata  output  32  read data; drives data_in; valid in the ack cycle.
REQ-011 Port err  output  1  high with ack when the transaction was rejected.
REQ-012 Port busy  output  1  high while a transaction is in flight (WAIT or RESP).
REQ-013 Port host_we  input  1  host preload write strobe.
REQ-014 Port host_addr  input  log2(DEPTH)  host word index.
REQ-015 Port host_wdata  input  32  host write data.
REQ-016 Port host_rdata  output  32  registered read of host_addr, one-cycle latency.
REQ-017 Port txn_count  output  16  completed-transaction counter.

Function
REQ-018 FSM states: IDLE, WAIT, RESP.
REQ-019 IDLE: req=1 latches addr/we/wdata and loads the latency counter with LAT-1, then moves to WAIT; with LAT=1 it moves directly to RESP.
REQ-020 WAIT: decrement the counter each cycle; go to RESP when it reaches 0; req, req_addr, req_we and req_wdata are ignored.
REQ-021 RESP: assert ack for exactly one cycle, then return to IDLE.
REQ-022 Latency: ack rises exactly LAT cycles after the accepting edge.
REQ-023 A req high in the cycle after ack is a new request (back-to-back); no idle gap is required.
REQ-024 Word index = latched addr[log2(DEPTH)+1:2].
REQ-025 Reject condition: addr[1:0] != 0, or addr >= 4*DEPTH; latched at accept.
REQ-026 On reject: err=1 with ack, rdata=32'hDEADBEEF, no memory write.
REQ-027 Valid read: rdata = memory word at the RESP edge; err=0.
REQ-028 Valid write: memory is updated at the RESP edge; rdata=0.
REQ-029 rdata and err hold their value until the next ack; both are 0 after reset.
REQ-030 Host write is accepted in any state; it takes effect at the same clock edge.
REQ-031 Host write and request write to the same word at the same edge: the request wins.
REQ-032 Request read and host write to the same word at the same edge: rdata returns the old value (read-before-write).
REQ-033 host_rdata returns the pre-edge contents (read-before-write on the host port).
REQ-034 txn_count increments on every ack, including rejected ones; it wraps from 16'hFFFF to 0.
REQ-035 A req deassertion during WAIT does not cancel the transaction; ack still fires.

Reset
REQ-036 rst forces the FSM to IDLE and clears ack, err, busy, rdata, txn_count and the latency counter, effective the next cycle.
REQ-037 rst mid-transaction: the in-flight transaction is dropped (no ack, no memory write).
REQ-038 Memory contents are not cleared by rst; host_rdata is cleared to 0.
REQ-039 A req that is high in the same cycle as rst is ignored.

Verification
REQ-040 LAT=2: host preload word 3 = 0x12345678, then req read addr 0x0C -> ack 2 cycles after accept, rdata=0x12345678, err=0, txn_count=1.
REQ-041 req write addr 0x10, data 0xCAFEF00D, then read addr 0x10 back-to-back (req high the cycle after ack) -> second ack returns 0xCAFEF00D.
REQ-042 req read addr 0x0E (misaligned) and addr 4*DEPTH -> each gives ack with err=1, rdata=0xDEADBEEF, memory unchanged, txn_count +2.
REQ-043 req write word 5 = 0xAAAA0000 and host write word 5 = 0x5555FFFF at the same edge -> word 5 = 0xAAAA0000.
REQ-044 rst asserted in WAIT of a write to word 7 -> no ack, word 7 unchanged, busy=0, txn_count=0 next cycle.
REQ-045 18 sequential reads (0x00..0x44) then 9 writes (0x00..0x20), each issued on ack, matching the multiplier load/store sequence -> 27 acks, each LAT cycles apart from its accept, txn_count=27.
